// File: rtl/reg_ctrl_seq_pkg.sv
// Shared definitions for the register-file control sequencer: widths, opcodes,
// ALU operation codes, FSM state encoding and the decoded-instruction record.
package reg_ctrl_seq_pkg;

    localparam int unsigned DW   = 8;
    localparam int unsigned IW   = 16;
    localparam int unsigned NREG = 16;
    localparam int unsigned SW   = $clog2(NREG);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_INC  = 4'h8;
    localparam logic [3:0] OP_DEC  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StWrite,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        ClsNop,
        ClsLdi,
        ClsMov,
        ClsAlu,
        ClsInc,
        ClsDec,
        ClsHalt,
        ClsIllegal
    } instr_class_e;

    typedef struct packed {
        logic [SW-1:0] rd;
        logic [SW-1:0] rs;
        logic [DW-1:0] imm;
        logic [2:0]    alu_op;
        instr_class_e  cls;
        logic          legal;
    } dec_t;

endpackage

// File: rtl/reg_ctrl_seq_if.sv
// Bus bundle between the sequencer and its environment: instruction fetch
// handshake, register-file controls/read-back and the external ALU.
//   master : the sequencer side (accepts instructions, drives register file/ALU op)
//   slave  : the environment side (instruction source, register file, ALU)
interface reg_ctrl_seq_if;
    import reg_ctrl_seq_pkg::*;

    logic          instr_valid;
    logic [IW-1:0] instr_data;
    logic          instr_ready;
    logic [SW-1:0] rf_in_select;
    logic [SW-1:0] rf_outb_select;
    logic [DW-1:0] rf_in;
    logic          rf_write_en;
    logic          rf_inc;
    logic          rf_dec;
    logic [DW-1:0] rf_outa;
    logic [DW-1:0] rf_outb;
    logic [2:0]    alu_op;
    logic [DW-1:0] alu_result;

    modport master (
        input  instr_valid, instr_data, rf_outa, rf_outb, alu_result,
        output instr_ready, rf_in_select, rf_outb_select, rf_in,
               rf_write_en, rf_inc, rf_dec, alu_op
    );

    modport slave (
        output instr_valid, instr_data, rf_outa, rf_outb, alu_result,
        input  instr_ready, rf_in_select, rf_outb_select, rf_in,
               rf_write_en, rf_inc, rf_dec, alu_op
    );

endinterface

// File: rtl/reg_ctrl_seq_instr_decoder.sv
// Combinational instruction decoder.
//   instr_i : 16-bit instruction {opcode, rd, rs, imm8} (rs and imm8 overlap)
//   dec_o   : register fields, immediate, ALU op, instruction class, legal flag
module reg_ctrl_seq_instr_decoder
    import reg_ctrl_seq_pkg::*;
(
    input  logic [IW-1:0] instr_i,
    output dec_t          dec_o
);

    logic [3:0] opcode;
    assign opcode = instr_i[15:12];

    always_comb begin
        dec_o.rd     = instr_i[11:8];
        dec_o.rs     = instr_i[7:4];
        dec_o.imm    = instr_i[7:0];
        dec_o.alu_op = ALU_ADD;
        dec_o.cls    = ClsIllegal;
        dec_o.legal  = 1'b1;
        unique case (opcode)
            OP_NOP:  dec_o.cls = ClsNop;
            OP_LDI:  dec_o.cls = ClsLdi;
            OP_MOV:  dec_o.cls = ClsMov;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                dec_o.cls    = ClsAlu;
                // ALU codes follow the opcode order starting at ADD.
                dec_o.alu_op = 3'(opcode - OP_ADD);
            end
            OP_INC:  dec_o.cls = ClsInc;
            OP_DEC:  dec_o.cls = ClsDec;
            OP_HALT: dec_o.cls = ClsHalt;
            default: dec_o.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/reg_ctrl_seq.sv
// Control sequencer in front of the 16x8 register file. Fetches one instruction
// at a time, decodes it, and drives register-file selects/strobes and the ALU op.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch handshake, register-file and ALU signals (master side)
//   busy       : high while an instruction is in flight (not FETCH, not HALT)
//   halted     : high once a HALT has executed; cleared only by reset
//   illegal    : one-cycle pulse on undefined opcode or out-of-range pair index
module reg_ctrl_seq
    import reg_ctrl_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    reg_ctrl_seq_if.master bus,
    output logic           busy,
    output logic           halted,
    output logic           illegal
);

    state_e        state_q, state_d;
    logic [IW-1:0] instr_q, instr_d;
    logic [DW-1:0] wb_q, wb_d;
    dec_t          dcd;

    reg_ctrl_seq_instr_decoder u_decoder (
        .instr_i (instr_q),
        .dec_o   (dcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            instr_q <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            wb_q    <= wb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        wb_d    = wb_q;

        // Selects and ALU op come straight from the latched instruction, so they
        // stay stable from DECODE until the next accept. The reset-time latched
        // value of zero decodes to NOP with all fields zero.
        bus.rf_in_select   = dcd.rd;
        bus.rf_outb_select = (dcd.cls == ClsInc || dcd.cls == ClsDec) ?
                             {1'b0, dcd.rd[SW-2:0]} : dcd.rs;
        bus.alu_op         = dcd.alu_op;
        bus.rf_in          = wb_q;

        bus.instr_ready = 1'b0;
        bus.rf_write_en = 1'b0;
        bus.rf_inc      = 1'b0;
        bus.rf_dec      = 1'b0;
        busy            = 1'b1;
        halted          = 1'b0;
        illegal         = 1'b0;

        unique case (state_q)
            StFetch: begin
                bus.instr_ready = 1'b1;
                busy            = 1'b0;
                if (bus.instr_valid) begin
                    instr_d = bus.instr_data;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                unique case (dcd.cls)
                    ClsNop: state_d = StFetch;
                    ClsLdi: begin
                        wb_d    = dcd.imm;
                        state_d = StWrite;
                    end
                    ClsMov: begin
                        wb_d    = bus.rf_outb;
                        state_d = StWrite;
                    end
                    ClsAlu, ClsInc, ClsDec: state_d = StExec;
                    ClsHalt: state_d = StHalt;
                    default: begin
                        illegal = 1'b0 | !dcd.legal | (dcd.cls == ClsIllegal);
                        state_d = StFetch;
                    end
                endcase
            end
            StExec: begin
                if (dcd.cls == ClsAlu) begin
                    wb_d    = bus.alu_result;
                    state_d = StWrite;
                end else begin
                    // Only pairs 0..7 exist; rd[3] set means no such pair.
                    if (dcd.rd[SW-1]) begin
                        illegal = 1'b1;
                    end else if (dcd.cls == ClsInc) begin
                        bus.rf_inc = 1'b1;
                    end else begin
                        bus.rf_dec = 1'b1;
                    end
                    state_d = StFetch;
                end
            end
            StWrite: begin
                bus.rf_write_en = 1'b1;
                state_d         = StFetch;
            end
            StHalt: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

endmodule
